// File: rtl/n64_vmode_ctrl_if.sv
// Bus bundle between the N64 video-info decoder / mode consumers and n64_vmode_ctrl.
// master: the upstream decoder plus downstream ack source; slave: the mode controller.
interface n64_vmode_ctrl_if;
  logic       nDSYNC;
  logic [3:0] Sync_pre;
  logic [3:0] Sync_cur;
  logic [3:0] vinfo_i;
  logic       mode_ack;
  logic       pix_strb_o;
  logic       mode_req;
  logic [1:0] mode_nxt;
  logic [1:0] mode_o;
  logic       lock_o;
  logic       err_o;
  logic [7:0] chg_cnt_o;

  modport master (
    output nDSYNC, Sync_pre, Sync_cur, vinfo_i, mode_ack,
    input  pix_strb_o, mode_req, mode_nxt, mode_o, lock_o, err_o, chg_cnt_o
  );

  modport slave (
    input  nDSYNC, Sync_pre, Sync_cur, vinfo_i, mode_ack,
    output pix_strb_o, mode_req, mode_nxt, mode_o, lock_o, err_o, chg_cnt_o
  );
endinterface

// File: rtl/n64_vmode_ctrl.sv
// N64 video-mode supervisor: qualifies {vmode, n64_480i} over QUAL_FRAMES frames,
// hands it to config consumers via mode_req/mode_ack, and strobes pixel capture.
// Optional feature macro: VMODE_CTRL_TIMEOUT_EN (abandon an unacked request after
// ACK_TIMEOUT frame ticks and flag err_o).
module n64_vmode_ctrl #(
  parameter int unsigned QUAL_FRAMES = 4,
  parameter int unsigned ACK_TIMEOUT = 2
) (
  input logic             VCLK,
  input logic             nRST,
  n64_vmode_ctrl_if.slave bus
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CHG_W    = 8;
  localparam logic [CNT_W-1:0] QUAL_MAX = CNT_W'(QUAL_FRAMES);
  localparam logic [CHG_W-1:0] CHG_SAT  = '1;

  typedef enum logic [1:0] {
    QUAL = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] qcnt, qcnt_n;
  logic [1:0]       cand, cand_n;
  logic [1:0]       mode, mode_n;
  logic             lock, lock_n;
  logic [CHG_W-1:0] chg_cnt, chg_cnt_n;
  logic [1:0]       nxt, nxt_n;
  logic             req, req_n;
  logic             pix_strb;
  logic             err;

  logic       frame_tick;
  logic [1:0] m;
  logic       unused_sync;

  assign frame_tick  = !bus.nDSYNC & bus.Sync_pre[3] & !bus.Sync_cur[3];
  assign m           = bus.vinfo_i[1:0];
  assign unused_sync = ^{bus.Sync_pre[2:0], bus.Sync_cur[2:0]};

`ifdef VMODE_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(ACK_TIMEOUT);
  logic [CNT_W-1:0] tcnt, tcnt_n;
  logic             err_n;
`else
  logic unused_cfg;
  assign unused_cfg = ^CNT_W'(ACK_TIMEOUT);
`endif

  // Capture strobe: fires the cycle after the last data word of a pixel
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) pix_strb <= 1'b0;
    else       pix_strb <= bus.nDSYNC & (bus.vinfo_i[3:2] == 2'b11);
  end

  // State and mode-tracking registers
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state   <= QUAL;
      qcnt    <= '0;
      cand    <= 2'b00;
      mode    <= 2'b00;
      lock    <= 1'b0;
      chg_cnt <= '0;
      nxt     <= 2'b00;
      req     <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      cand    <= cand_n;
      mode    <= mode_n;
      lock    <= lock_n;
      chg_cnt <= chg_cnt_n;
      nxt     <= nxt_n;
      req     <= req_n;
    end
  end

`ifdef VMODE_CTRL_TIMEOUT_EN
  // Handshake timeout counter and sticky error flag
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      err  <= err_n;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Next-state: frame qualification, request/ack handshake, change counting
  always_comb begin
    state_n   = state;
    qcnt_n    = qcnt;
    cand_n    = cand;
    mode_n    = mode;
    lock_n    = lock;
    chg_cnt_n = chg_cnt;
    nxt_n     = nxt;
    req_n     = 1'b0;
`ifdef VMODE_CTRL_TIMEOUT_EN
    tcnt_n    = '0;
    err_n     = err;
`endif

    case (state)
      IDLE: begin
        if (frame_tick && (m != mode)) begin
          state_n = (QUAL_MAX == CNT_W'(1)) ? REQ : QUAL;
          cand_n  = m;
          qcnt_n  = CNT_W'(1);
        end
      end

      QUAL: begin
        if (frame_tick) begin
          if ((qcnt != '0) && (m == cand)) begin
            qcnt_n = qcnt + CNT_W'(1);
            if (qcnt_n >= QUAL_MAX) state_n = REQ;
          end else if (lock && (m == mode)) begin
            // single-frame glitch away from the locked mode: drop it
            state_n = IDLE;
            qcnt_n  = '0;
          end else begin
            cand_n = m;
            qcnt_n = CNT_W'(1);
            if (QUAL_MAX == CNT_W'(1)) state_n = REQ;
          end
        end
      end

      REQ: begin
        if (bus.mode_ack) begin
          state_n = IDLE;
          qcnt_n  = '0;
          mode_n  = cand;
          lock_n  = 1'b1;
          if (((cand != mode) || !lock) && (chg_cnt != CHG_SAT))
            chg_cnt_n = chg_cnt + CHG_W'(1);
`ifdef VMODE_CTRL_TIMEOUT_EN
          err_n = 1'b0;
        end else if (frame_tick) begin
          if ((tcnt + CNT_W'(1)) >= TMO_MAX) begin
            state_n = QUAL;
            qcnt_n  = '0;
            err_n   = 1'b1;
          end else begin
            tcnt_n = tcnt + CNT_W'(1);
          end
        end else begin
          tcnt_n = tcnt;
`endif
        end
      end

      default: state_n = QUAL;
    endcase

    // mode_nxt is loaded on entry to REQ and held everywhere else
    if (state_n == REQ) begin
      req_n = 1'b1;
      nxt_n = cand_n;
    end
  end

  assign bus.pix_strb_o = pix_strb;
  assign bus.mode_req   = req;
  assign bus.mode_nxt   = nxt;
  assign bus.mode_o     = mode;
  assign bus.lock_o     = lock;
  assign bus.err_o      = err;
  assign bus.chg_cnt_o  = chg_cnt;

endmodule
